calc_seq: RTL and testbench
===========================

Name: calc_seq

Overview:
- Command sequencer that acts as the initiator for the 4-entry, 3-bit calculator register file.
- Accepts one calculator instruction at a time over a valid/ready handshake.
- Drives RF read port A and read port B to fetch operands, computes the result with a small ALU, and drives the RF write port to write the result back.
- Reports completion with a one-cycle done pulse plus result and overflow status.

Parameters:
- DW, 3, data width of RF entries, operands, immediate and result.
- AW, 2, RF address width (2^AW entries).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  opcode: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 LDI, 111 MOV.
- cmd_dst  in  AW  destination register.
- cmd_srca  in  AW  source A register.
- cmd_srcb  in  AW  source B register.
- cmd_imm  in  DW  immediate, used by LDI only.
- rea  out  1  RF read enable, port A.
- raa  out  AW  RF read address, port A.
- reb  out  1  RF read enable, port B.
- rab  out  AW  RF read address, port B.
- douta  in  DW  RF read data, port A (combinational from RF).
- doutb  in  DW  RF read data, port B (combinational from RF).
- we  out  1  RF write enable.
- wa  out  AW  RF write address.
- din  out  DW  RF write data.
- busy  out  1  command in flight.
- done  out  1  one-cycle completion pulse.
- result  out  DW  last computed result, held until the next done.
- ovf  out  1  overflow of last command, held until the next done.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE; rea, reb, we, done, busy, ovf = 0; raa, rab, wa, din, result = 0. cmd_ready = 0 while rst is high.
- All RF-side outputs and status outputs are registered.
- cmd_ready = 1 exactly when state is IDLE and rst = 0.
- Accept: cmd_valid & cmd_ready on the edge ending cycle T. The command fields are latched on that edge and are ignored at all other times.

State sequence (one cycle each):
- IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE.
- Fixed latency for every opcode; next accept is possible at the earliest in cycle T+5.
- READ (T+1):
  - raa = srca and rab = srcb.
  - rea = 1 for ADD, SUB, AND, OR, XOR, MOV; reb = 1 for ADD, SUB, AND, OR, XOR.
  - Both enables are 0 for NOP and LDI.
  - douta/doutb are captured into operand registers at the end of T+1.
- EXEC (T+2):
  - The ALU result is computed from the operand registers and registered.
  - Enables are back to 0.
- WRITE (T+3):
  - we = 1, wa = dst, din = result, for exactly one cycle.
  - we stays 0 for NOP.
- DONE (T+4):
  - done = 1 for one cycle; result and ovf are updated in the same cycle.
- busy = 1 in READ through DONE.

Arithmetic (all results mod 2^DW):
- ADD: a + b; ovf = carry out.
- SUB: a - b; ovf = borrow (a < b, unsigned).
- AND, OR, XOR: bitwise; ovf = 0.
- LDI: result = imm; ovf = 0.
- MOV: result = a; ovf = 0.
- NOP: result = 0; ovf = 0.

Boundary conditions:
- dst equal to srca or srcb is legal: the read in T+1 precedes the write in T+3, so old data is used.
- cmd_valid held high outside IDLE has no effect; fields may change freely.
- rst asserted in any state: the next state is IDLE and all outputs return to reset values on that edge. A write not yet issued is dropped. we is never 1 in a cycle where rst was sampled high on the previous edge.
- Unused opcodes: none, all 8 codes are defined.

Decomposition:
- Package calc_pkg holds:
  - DW/AW defaults;
  - opcode constants OP_NOP..OP_MOV;
  - the state encoding (S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE);
  - a helper function opcode->{uses_a, uses_b, writes}.
- One sub-module, calc_alu: purely combinational (op, a, b, imm) -> (res, ovf), instantiated in calc_seq.

Test Plan:
- Reset, then LDI dst=1 imm=5 accepted at T -> rea = reb = 0 throughout; T+3 we=1 wa=1 din=5; T+4 done=1 result=5 ovf=0.
- Preload r1=5, r2=3; ADD dst=0 a=1 b=2 -> T+1 rea=reb=1 raa=1 rab=2; T+3 we=1 wa=0 din=0; T+4 result=0 ovf=1.
- SUB dst=3 a=2 b=1 (3-5) -> din=6, ovf=1; then SUB dst=3 a=1 b=2 (5-3) -> din=2, ovf=0; then MOV dst=2 a=3 -> din=2.
- NOP -> no cycle with we=1; done pulses at T+4 with result=0 ovf=0; cmd_ready returns to 1 at T+5.
- cmd_valid held high with changing fields -> cmd_ready=0 for T+1..T+4; second command accepted at T+5 uses the fields present in T+5 only.
- rst=1 sampled while in EXEC of an ADD -> we never goes to 1; all outputs 0 the next cycle; after rst drops, cmd_ready=1 and a following LDI completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator command sequencer:
//   - default data / address widths of the 4-entry register file
//   - opcode constants
//   - sequencer state encoding
//   - op_usage(): which RF ports an opcode reads and whether it writes back
// ---------------------------------------------------------------------------
package calc_pkg;

  localparam int DW_DEF = 3;
  localparam int AW_DEF = 2;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic uses_a;
    logic uses_b;
    logic writes;
  } op_use_t;

  function automatic op_use_t op_usage(input logic [2:0] op);
    op_use_t u;
    u.uses_a = 1'b0;
    u.uses_b = 1'b0;
    u.writes = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        u.uses_a = 1'b1;
        u.uses_b = 1'b1;
      end
      OP_MOV:  u.uses_a = 1'b1;
      OP_LDI:  u.writes = 1'b1;
      OP_NOP:  u.writes = 1'b0;
      default: u.writes = 1'b1;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// ---------------------------------------------------------------------------
// calc_alu
// Purely combinational ALU for the calculator sequencer.
// Ports:
//   op   in  3   opcode (calc_pkg OP_*)
//   a    in  DW  operand A (register file port A)
//   b    in  DW  operand B (register file port B)
//   imm  in  DW  immediate (LDI only)
//   res  out DW  result, modulo 2^DW
//   ovf  out 1   carry out (ADD) / unsigned borrow (SUB), else 0
// ---------------------------------------------------------------------------
module calc_alu
  import calc_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] res,
  output logic          ovf
);

  // One extra bit catches the carry of ADD and the borrow of SUB.
  logic [DW:0] sum_w;
  logic [DW:0] diff_w;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        res = sum_w[DW-1:0];
        ovf = sum_w[DW];
      end
      OP_SUB: begin
        res = diff_w[DW-1:0];
        ovf = diff_w[DW];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_LDI:  res = imm;
      OP_MOV:  res = a;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/calc_seq.sv
// ---------------------------------------------------------------------------
// calc_seq
// Command sequencer driving a 4-entry calculator register file. One command
// at a time: IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE, one cycle each.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_op/dst/srca/srcb/imm      command fields, latched on accept
//   rea/raa, reb/rab              RF read ports A/B (registered)
//   douta, doutb                  RF read data (combinational from RF)
//   we/wa/din                     RF write port (registered)
//   busy                          command in flight (READ..DONE)
//   done                          one-cycle completion pulse
//   result, ovf                   status of last command, held until next done
// ---------------------------------------------------------------------------
module calc_seq
  import calc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srca,
  input  logic [AW-1:0] cmd_srcb,
  input  logic [DW-1:0] cmd_imm,
  output logic          rea,
  output logic [AW-1:0] raa,
  output logic          reb,
  output logic [AW-1:0] rab,
  input  logic [DW-1:0] douta,
  input  logic [DW-1:0] doutb,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] din,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          ovf
);

  state_e        state_q, state_d;

  // Latched command
  logic [2:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [DW-1:0] imm_q;

  // Operands captured at the end of READ, ALU result registered in EXEC
  logic [DW-1:0] a_q, b_q;
  logic [DW-1:0] res_q;
  logic          res_ovf_q;

  // Registered outputs
  logic          rea_q, reb_q, we_q, busy_q, done_q, ovf_q;
  logic [AW-1:0] raa_q, rab_q, wa_q;
  logic [DW-1:0] din_q, result_q;

  logic [DW-1:0] alu_res;
  logic          alu_ovf;
  op_use_t       cmd_use;
  op_use_t       cur_use;

  assign cmd_use = op_usage(cmd_op);
  assign cur_use = op_usage(op_q);

  calc_alu #(.DW(DW)) u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .imm (imm_q),
    .res (alu_res),
    .ovf (alu_ovf)
  );

  // Ready is gated by rst directly so nothing is accepted on a reset edge.
  assign cmd_ready = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      dst_q     <= '0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      res_ovf_q <= 1'b0;
      rea_q     <= 1'b0;
      reb_q     <= 1'b0;
      raa_q     <= '0;
      rab_q     <= '0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      din_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            dst_q  <= cmd_dst;
            imm_q  <= cmd_imm;
            raa_q  <= cmd_srca;
            rab_q  <= cmd_srcb;
            rea_q  <= cmd_use.uses_a;
            reb_q  <= cmd_use.uses_b;
            busy_q <= 1'b1;
          end
        end
        S_READ: begin
          // RF data is combinational on the registered addresses.
          a_q   <= douta;
          b_q   <= doutb;
          rea_q <= 1'b0;
          reb_q <= 1'b0;
        end
        S_EXEC: begin
          res_q     <= alu_res;
          res_ovf_q <= alu_ovf;
          we_q      <= cur_use.writes;
          wa_q      <= dst_q;
          din_q     <= alu_res;
        end
        S_WRITE: begin
          we_q     <= 1'b0;
          done_q   <= 1'b1;
          result_q <= res_q;
          ovf_q    <= res_ovf_q;
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rea    = rea_q;
  assign raa    = raa_q;
  assign reb    = reb_q;
  assign rab    = rab_q;
  assign we     = we_q;
  assign wa     = wa_q;
  assign din    = din_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_calc_seq.sv
// ---------------------------------------------------------------------------
// tb_calc_seq
// Drives calc_seq with directed and random commands, emulates the register
// file it talks to, and checks every cycle of each transaction against a
// reference register file updated with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_calc_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
  logic [2:0] cmd_imm;
  logic       rea, reb, we, busy, done, ovf;
  logic [1:0] raa, rab, wa;
  logic [2:0] douta, doutb, din, result;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Register file seen by the DUT, and the reference contents it should hold
  logic [2:0] rf     [4];
  int         ref_rf [4];

  always #5 clk = ~clk;

  calc_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_srca  (cmd_srca),
    .cmd_srcb  (cmd_srcb),
    .cmd_imm   (cmd_imm),
    .rea       (rea),
    .raa       (raa),
    .reb       (reb),
    .rab       (rab),
    .douta     (douta),
    .doutb     (doutb),
    .we        (we),
    .wa        (wa),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf)
  );

  assign douta = rf[raa];
  assign doutb = rf[rab];

  always @(posedge clk) begin
    if (we) rf[wa] <= din;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks_cnt++;
    if (obs != exp_v) begin
      errors_cnt++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic scramble();
    cmd_op   = 3'($urandom_range(7));
    cmd_dst  = 2'($urandom_range(3));
    cmd_srca = 2'($urandom_range(3));
    cmd_srcb = 2'($urandom_range(3));
    cmd_imm  = 3'($urandom_range(7));
  endtask

  // Issue one command at the next opportunity and check it through T+5.
  // hold=1 keeps cmd_valid high with garbage fields while the command runs.
  task automatic run_cmd(input int op, input int dst, input int a, input int b,
                         input int imm, input bit hold);
    int n, ea, eb, r, ov;
    bit ua, ub, wr;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_dst   = 2'(dst);
    cmd_srca  = 2'(a);
    cmd_srcb  = 2'(b);
    cmd_imm   = 3'(imm);

    ea = ref_rf[a];
    eb = ref_rf[b];
    ua = (op >= 1 && op <= 5) || op == 7;
    ub = (op >= 1 && op <= 5);
    wr = (op != 0);
    r  = 0;
    ov = 0;
    case (op)
      1: begin r = (ea + eb) % 8; ov = (ea + eb > 7) ? 1 : 0; end
      2: begin r = (ea - eb + 8) % 8; ov = (ea < eb) ? 1 : 0; end
      3: r = ea & eb;
      4: r = ea | eb;
      5: r = ea ^ eb;
      6: r = imm;
      7: r = ea;
      default: r = 0;
    endcase

    @(negedge clk);  // T+1: READ
    chk("t1_rea", int'(rea), int'(ua));
    chk("t1_reb", int'(reb), int'(ub));
    chk("t1_raa", int'(raa), a);
    chk("t1_rab", int'(rab), b);
    chk("t1_busy", int'(busy), 1);
    chk("t1_ready", int'(cmd_ready), 0);
    chk("t1_we", int'(we), 0);
    if (!hold) cmd_valid = 1'b0;
    scramble();

    @(negedge clk);  // T+2: EXEC
    chk("t2_rea", int'(rea), 0);
    chk("t2_reb", int'(reb), 0);
    chk("t2_we", int'(we), 0);
    chk("t2_ready", int'(cmd_ready), 0);
    scramble();

    @(negedge clk);  // T+3: WRITE
    chk("t3_we", int'(we), int'(wr));
    if (wr) begin
      chk("t3_wa", int'(wa), dst);
      chk("t3_din", int'(din), r);
      ref_rf[dst] = r;
    end
    chk("t3_done", int'(done), 0);
    scramble();

    @(negedge clk);  // T+4: DONE
    chk("t4_done", int'(done), 1);
    chk("t4_result", int'(result), r);
    chk("t4_ovf", int'(ovf), ov);
    chk("t4_we", int'(we), 0);
    chk("t4_busy", int'(busy), 1);
    chk("t4_ready", int'(cmd_ready), 0);
    scramble();

    @(negedge clk);  // T+5: back in IDLE
    chk("t5_ready", int'(cmd_ready), 1);
    chk("t5_done", int'(done), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_result_hold", int'(result), r);
    $display("txn op=%0d dst=%0d a=%0d b=%0d imm=%0d hold=%0d -> res=%0d ovf=%0d",
             op, dst, a, b, imm, hold, r, ov);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rea"}, int'(rea), 0);
    chk({tag, "_reb"}, int'(reb), 0);
    chk({tag, "_we"}, int'(we), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_raa"}, int'(raa), 0);
    chk({tag, "_rab"}, int'(rab), 0);
    chk({tag, "_wa"}, int'(wa), 0);
    chk({tag, "_din"}, int'(din), 0);
    chk({tag, "_result"}, int'(result), 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rf[i]     = 3'd0;
      ref_rf[i] = 0;
    end
    rst       = 1'b1;
    cmd_valid = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 0);
    check_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(cmd_ready), 1);

    // Directed sequence
    run_cmd(6, 1, 0, 0, 5, 1'b0);  // LDI r1=5
    run_cmd(6, 2, 0, 0, 3, 1'b0);  // LDI r2=3
    run_cmd(1, 0, 1, 2, 0, 1'b0);  // ADD 5+3 -> 0, carry
    run_cmd(2, 3, 2, 1, 0, 1'b0);  // SUB 3-5 -> 6, borrow
    run_cmd(2, 3, 1, 2, 0, 1'b0);  // SUB 5-3 -> 2
    run_cmd(7, 2, 3, 0, 0, 1'b0);  // MOV r2=r3
    run_cmd(0, 1, 1, 1, 7, 1'b0);  // NOP
    run_cmd(5, 1, 1, 1, 0, 1'b1);  // XOR dst==src, valid held afterwards
    run_cmd(3, 2, 0, 3, 0, 1'b1);  // accepted at T+5 with fresh fields
    run_cmd(4, 0, 2, 3, 0, 1'b0);

    // Reset during EXEC of an ADD: the write must be dropped.
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_dst   = 2'd3;
    cmd_srca  = 2'd1;
    cmd_srcb  = 2'd2;
    @(negedge clk);  // T+1
    cmd_valid = 1'b0;
    @(negedge clk);  // T+2 (EXEC)
    chk("rstx_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstx_ready", int'(cmd_ready), 0);
    check_all_zero("rstx");
    rst = 1'b0;
    @(negedge clk);
    chk("rstx_ready_after", int'(cmd_ready), 1);
    chk("rstx_we_after", int'(we), 0);
    $display("txn reset during EXEC, write dropped");
    run_cmd(6, 0, 0, 0, 4, 1'b0);  // LDI completes normally

    // Random commands
    for (int k = 0; k < 40; k++) begin
      run_cmd(int'($urandom_range(7)), int'($urandom_range(3)),
              int'($urandom_range(3)), int'($urandom_range(3)),
              int'($urandom_range(7)), bit'($urandom_range(1)));
    end
    cmd_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) chk("rf_final", int'(rf[i]), ref_rf[i]);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
